minmax_tracker: RTL and testbench
=================================

Name: minmax_tracker

Overview:
- Streaming extrema stage placed directly downstream of the 8-bit `comparator`.
- Consumes the comparator's gr/le/eq flags to track the running maximum and minimum of a sample frame, along with the first-occurrence index of each.
- At frame end it emits the results with a one-cycle valid pulse.
- Sits between the ALU datapath output and the status/readout logic.

Parameters:
- N, 8: sample width in bits; passed to comparator instances.
- CNT_W, 8: width of sample counter and index outputs.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous frame abort.
- in_valid  input  1  sample present on in_data.
- in_ready  output  1  stage can accept a sample.
- in_data  input  N  sample value, unsigned.
- in_last  input  1  marks final sample of frame; qualified by accept.
- out_valid  output  1  one-cycle pulse, results valid.
- out_max  output  N  frame maximum.
- out_min  output  N  frame minimum.
- out_max_idx  output  CNT_W  index of first occurrence of maximum.
- out_min_idx  output  CNT_W  index of first occurrence of minimum.
- out_count  output  CNT_W  number of samples in frame, saturating.

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-high on rst. All state and outputs are 0 under reset; FSM enters IDLE.
- Accept: accept = in_valid & in_ready. No sample is consumed otherwise.
- in_ready = 1 in IDLE and RUN, 0 in DONE.
- FSM states: IDLE, RUN, DONE.
  - IDLE, on accept without in_last:
    - cur_max = cur_min = in_data.
    - max_idx = min_idx = 0.
    - cnt = 1.
    - Next state RUN.
  - IDLE, on accept with in_last: same load as above; next state DONE.
  - RUN, on accept:
    - Compare in_data against cur_max via comparator instance U_MAX (A=in_data, B=cur_max). If gr, load cur_max and set max_idx = cnt.
    - Compare in_data against cur_min via comparator instance U_MIN (A=in_data, B=cur_min). If le, load cur_min and set min_idx = cnt.
    - eq updates neither value nor index: ties keep the earliest index.
    - cnt increments.
    - If in_last, next state DONE; else stay in RUN.
  - RUN, no accept: hold all state.
  - DONE, one cycle only:
    - out_valid = 1.
    - out_* registers are loaded on the cycle of transition into DONE, so they are valid while out_valid = 1.
    - Next state IDLE unconditionally.
- Latency: out_valid asserts exactly 1 cycle after the in_last sample is accepted.
- Output hold: out_* hold their last results until the next frame completes. out_valid is high for only one cycle per frame.
- Counter saturation: cnt saturates at 2^CNT_W-1.
  - Once saturated, indices recorded at saturation use the saturated value.
  - Comparisons continue; the frame is still processed correctly for value.
- clear:
  - Highest priority after rst. Forces IDLE on the next edge and discards the open frame.
  - No out_valid is produced. out_* are unchanged.
  - A sample presented in the same cycle as clear is dropped, even if in_ready = 1.
- clear in DONE: out_valid still pulses that cycle, since the output is already registered. Next state is IDLE.
- Comparator usage: comparator outputs are combinational and are consumed in the same cycle. The stage adds no extra pipelining.
- Comparisons are unsigned, N-bit. No width extension is needed.

Decomposition:
- Shared package `minmax_pkg`:
  - FSM state encoding localparams: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Counter max constant, derived from CNT_W.
- Sub-module: two instances of the existing `comparator` (U_MAX, U_MIN) with N passed through.
- No other sub-module is warranted.

Test Plan:
- Frame 5,9,3,9,1 with in_last on the 1 → one out_valid 1 cycle after the last accept; max=9, max_idx=1, min=1, min_idx=4, count=5.
- Single-sample frame 0x7F with in_last → max=min=0x7F, both idx=0, count=1; in_ready=0 during the DONE cycle.
- Frame 4,4,4 → max=min=4, both idx=0 (tie keeps earliest), count=3.
- Frame 1,2 then clear asserted while sending 200 → no out_valid; out_* retain the previous frame's values. New frame 10,20(last) → max=20, min=10, count=2.
- Boundary values 0x00, 0xFF with in_valid gaps (idle cycles between samples) → max=0xFF idx=1, min=0x00 idx=0, count=2. Gaps cause no state change.
- rst asserted asynchronously mid-frame (between clock edges) → all outputs 0 immediately, state IDLE. Post-reset frame 3(last) → max=min=3, count=1.

Source files
------------

// File: rtl/minmax_pkg.sv
// Shared definitions for the min/max tracking stage: FSM encoding and
// default counter sizing.
package minmax_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int CNT_W_DEFAULT = 8;
  localparam logic [CNT_W_DEFAULT-1:0] CNT_MAX_DEFAULT = {CNT_W_DEFAULT{1'b1}};

endpackage

// File: rtl/comparator.sv
// Unsigned N-bit magnitude comparator: a greater than, less than, or equal to b.
module comparator #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         gr,
  output logic         le,
  output logic         eq
);

  assign gr = (a > b);
  assign le = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/minmax_tracker.sv
// Streaming extrema stage: tracks running max/min of a sample frame with the
// first-occurrence index of each, and publishes results on a one-cycle pulse.
module minmax_tracker
  import minmax_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  output logic [N-1:0]     out_max,
  output logic [N-1:0]     out_min,
  output logic [CNT_W-1:0] out_max_idx,
  output logic [CNT_W-1:0] out_min_idx,
  output logic [CNT_W-1:0] out_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r, state_n;
  logic [N-1:0]     cur_max_r, cur_max_n, cur_min_r, cur_min_n;
  logic [CNT_W-1:0] max_idx_r, max_idx_n, min_idx_r, min_idx_n;
  logic [CNT_W-1:0] cnt_r, cnt_n;
  logic             in_ready_r, out_valid_r;
  logic [N-1:0]     out_max_r, out_min_r;
  logic [CNT_W-1:0] out_max_idx_r, out_min_idx_r, out_count_r;
  logic             accept_s, done_s;
  logic             max_gr_s, max_le_s, max_eq_s;
  logic             min_gr_s, min_le_s, min_eq_s;
  logic             cmp_unused_s;

  comparator #(.N(N)) U_MAX (
    .a  (in_data),
    .b  (cur_max_r),
    .gr (max_gr_s),
    .le (max_le_s),
    .eq (max_eq_s)
  );

  comparator #(.N(N)) U_MIN (
    .a  (in_data),
    .b  (cur_min_r),
    .gr (min_gr_s),
    .le (min_le_s),
    .eq (min_eq_s)
  );

  // Ties and the opposite-direction flags leave the extrema untouched.
  assign cmp_unused_s = ^{max_le_s, max_eq_s, min_gr_s, min_eq_s};

  // A sample arriving together with clear is dropped.
  assign accept_s = in_valid & in_ready_r & ~clear;
  assign done_s   = (state_n == ST_DONE);

  // Next-state and running-extrema update.
  always_comb begin
    state_n   = state_r;
    cur_max_n = cur_max_r;
    cur_min_n = cur_min_r;
    max_idx_n = max_idx_r;
    min_idx_n = min_idx_r;
    cnt_n     = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          cur_max_n = in_data;
          cur_min_n = in_data;
          max_idx_n = {CNT_W{1'b0}};
          min_idx_n = {CNT_W{1'b0}};
          cnt_n     = CNT_ONE;
          state_n   = in_last ? ST_DONE : ST_RUN;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (accept_s) begin
          if (max_gr_s) begin
            cur_max_n = in_data;
            max_idx_n = cnt_r;
          end else begin
            cur_max_n = cur_max_r;
          end
          if (min_le_s) begin
            cur_min_n = in_data;
            min_idx_n = cnt_r;
          end else begin
            cur_min_n = cur_min_r;
          end
          cnt_n   = (cnt_r == CNT_MAX) ? CNT_MAX : (cnt_r + CNT_ONE);
          state_n = in_last ? ST_DONE : ST_RUN;
        end else begin
          state_n = ST_RUN;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    if (clear) begin
      state_n = ST_IDLE;
    end else begin
      state_n = state_n;
    end
  end

  // State, running extrema and registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      cur_max_r     <= {N{1'b0}};
      cur_min_r     <= {N{1'b0}};
      max_idx_r     <= {CNT_W{1'b0}};
      min_idx_r     <= {CNT_W{1'b0}};
      cnt_r         <= {CNT_W{1'b0}};
      in_ready_r    <= 1'b0;
      out_valid_r   <= 1'b0;
      out_max_r     <= {N{1'b0}};
      out_min_r     <= {N{1'b0}};
      out_max_idx_r <= {CNT_W{1'b0}};
      out_min_idx_r <= {CNT_W{1'b0}};
      out_count_r   <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_n;
      cur_max_r   <= cur_max_n;
      cur_min_r   <= cur_min_n;
      max_idx_r   <= max_idx_n;
      min_idx_r   <= min_idx_n;
      cnt_r       <= cnt_n;
      in_ready_r  <= (state_n != ST_DONE);
      out_valid_r <= done_s;
      if (done_s) begin
        out_max_r     <= cur_max_n;
        out_min_r     <= cur_min_n;
        out_max_idx_r <= max_idx_n;
        out_min_idx_r <= min_idx_n;
        out_count_r   <= cnt_n;
      end
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign out_max     = out_max_r;
  assign out_min     = out_min_r;
  assign out_max_idx = out_max_idx_r;
  assign out_min_idx = out_min_idx_r;
  assign out_count   = out_count_r;

endmodule

// File: tb/tb_minmax_tracker.sv
// Directed self-checking bench for minmax_tracker: frame results, ties,
// clear abort, idle gaps, counter saturation and asynchronous reset.
module tb_minmax_tracker;

  logic       clk = 1'b0;
  logic       rst, clear, in_valid, in_ready, in_last, out_valid;
  logic [7:0] in_data, out_max, out_min, out_max_idx, out_min_idx, out_count;
  int checks = 0;
  int errors = 0;

  minmax_tracker #(.N(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_max(out_max), .out_min(out_min),
    .out_max_idx(out_max_idx), .out_min_idx(out_min_idx), .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    int n = 0;
    while (in_ready !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    if (n >= 10) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic chk_res(input string tag, input logic [7:0] mx, input logic [7:0] mxi,
                         input logic [7:0] mn, input logic [7:0] mni, input logic [7:0] cnt);
    chk({tag, "_max"},     {24'd0, out_max},     {24'd0, mx});
    chk({tag, "_max_idx"}, {24'd0, out_max_idx}, {24'd0, mxi});
    chk({tag, "_min"},     {24'd0, out_min},     {24'd0, mn});
    chk({tag, "_min_idx"}, {24'd0, out_min_idx}, {24'd0, mni});
    chk({tag, "_count"},   {24'd0, out_count},   {24'd0, cnt});
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = 8'd0; in_last = 1'b0;
    tick(); tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk_res("rst", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    rst = 1'b0;
    tick();
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // Frame 5,9,3,9,1
    send(8'd5, 1'b0); send(8'd9, 1'b0); send(8'd3, 1'b0); send(8'd9, 1'b0);
    chk("f1_no_valid_early", {31'd0, out_valid}, 32'd0);
    send(8'd1, 1'b1);
    chk("f1_valid", {31'd0, out_valid}, 32'd1);
    chk("f1_done_ready", {31'd0, in_ready}, 32'd0);
    chk_res("f1", 8'd9, 8'd1, 8'd1, 8'd4, 8'd5);
    tick();
    chk("f1_pulse_end", {31'd0, out_valid}, 32'd0);
    chk("f1_ready_back", {31'd0, in_ready}, 32'd1);
    chk_res("f1_hold", 8'd9, 8'd1, 8'd1, 8'd4, 8'd5);

    // Single-sample frame
    send(8'h7F, 1'b1);
    chk("f2_valid", {31'd0, out_valid}, 32'd1);
    chk("f2_done_ready", {31'd0, in_ready}, 32'd0);
    chk_res("f2", 8'h7F, 8'd0, 8'h7F, 8'd0, 8'd1);

    // All ties keep index 0
    send(8'd4, 1'b0); send(8'd4, 1'b0); send(8'd4, 1'b1);
    chk("f3_valid", {31'd0, out_valid}, 32'd1);
    chk_res("f3", 8'd4, 8'd0, 8'd4, 8'd0, 8'd3);

    // Aborted frame: clear drops the 200 sample and produces no result
    send(8'd1, 1'b0); send(8'd2, 1'b0);
    clear = 1'b1; in_valid = 1'b1; in_data = 8'd200; in_last = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    chk("clr_no_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("clr_no_valid2", {31'd0, out_valid}, 32'd0);
    chk_res("clr_hold", 8'd4, 8'd0, 8'd4, 8'd0, 8'd3);
    send(8'd10, 1'b0); send(8'd20, 1'b1);
    chk("f4_valid", {31'd0, out_valid}, 32'd1);
    chk_res("f4", 8'd20, 8'd1, 8'd10, 8'd0, 8'd2);

    // Boundary values with idle gaps
    tick();
    send(8'h00, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    chk("gap_no_valid", {31'd0, out_valid}, 32'd0);
    send(8'hFF, 1'b1);
    chk("f5_valid", {31'd0, out_valid}, 32'd1);
    chk_res("f5", 8'hFF, 8'd1, 8'h00, 8'd0, 8'd2);

    // Saturation: 300 samples; 200 at index 260 and 10 at index 270
    for (int i = 0; i < 300; i++) begin
      logic [7:0] v;
      v = (i == 0) ? 8'd50 : (i == 260) ? 8'd200 : (i == 270) ? 8'd10 : 8'd100;
      send(v, (i == 299) ? 1'b1 : 1'b0);
    end
    chk("sat_valid", {31'd0, out_valid}, 32'd1);
    chk_res("sat", 8'd200, 8'd255, 8'd10, 8'd255, 8'd255);

    // Asynchronous reset between edges
    send(8'd50, 1'b0); send(8'd60, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_ready", {31'd0, in_ready}, 32'd0);
    chk_res("arst", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    tick();
    rst = 1'b0;
    send(8'd3, 1'b1);
    chk("f6_valid", {31'd0, out_valid}, 32'd1);
    chk_res("f6", 8'd3, 8'd0, 8'd3, 8'd0, 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
